// File: rtl/smpl_trigger_ctrl.sv
// smpl_trigger_ctrl: decimating level/edge trigger sequencer streaming SIZE samples to the renderer FIFO
// Optional macro SMPL_TRIG_AUTO_EN: force a trigger after AUTO decimated ticks spent in Wait
module smpl_trigger_ctrl #(
    parameter int SN   = 8,
    parameter int SIZE = 64,
    parameter int DW   = 16,
    parameter int AUTO = 4096
) (
    input  logic          clkSmpl,
    input  logic          n_reset,
    input  logic          adc_valid,
    input  logic [SN-1:0] adc,
    input  logic          arm,
    input  logic          abort,
    input  logic [DW-1:0] cfg_div,
    input  logic [DW-1:0] cfg_holdoff,
    input  logic [SN-1:0] cfg_level,
    input  logic          cfg_edge,
    input  logic          smpl_req,
    output logic          smpl_valid,
    output logic [SN-1:0] smpl,
    output logic          busy,
    output logic          triggered,
    output logic          trig_auto
);
    localparam int CW = $clog2(SIZE + 1);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT, STRM} state_t;
    state_t state, state_nx;
    logic [DW-1:0] dcnt, hcnt;
    logic [SN-1:0] prev;
    logic [CW-1:0] cnt, cnt_inc;
    logic pvld, tick, hit, fire, deliver, auto_fire, track;

    assign tick    = adc_valid && dcnt == '0;
    assign track   = tick && (state == HOLD || state == WAIT);
    assign hit     = pvld && (cfg_edge ? (prev > cfg_level && adc <= cfg_level)
                                       : (prev < cfg_level && adc >= cfg_level));
    assign fire    = state == WAIT && tick && (hit || auto_fire);
    assign deliver = !abort && tick && smpl_req && (state == STRM || fire);
    assign cnt_inc = cnt + 1'b1;

    // Next state: abort wins, then frame completion, then the normal sequence
    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = IDLE;
        else if (deliver && cnt_inc == CW'(SIZE))
            state_nx = IDLE;
        else if (state == IDLE && arm)
            state_nx = HOLD;
        else if (state == HOLD && hcnt == '0)
            state_nx = WAIT;
        else if (fire)
            state_nx = STRM;
    end

    // State, counters, trigger history and registered outputs
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            dcnt       <= '0;
            hcnt       <= '0;
            prev       <= '0;
            pvld       <= 1'b0;
            cnt        <= '0;
            smpl_valid <= 1'b0;
            smpl       <= '0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            state      <= state_nx;
            dcnt       <= (state == IDLE) ? '0 : tick ? cfg_div : adc_valid ? dcnt - 1'b1 : dcnt;
            hcnt       <= (state == IDLE) ? cfg_holdoff
                        : (state == HOLD && tick && hcnt != '0) ? hcnt - 1'b1 : hcnt;
            prev       <= track ? adc : prev;
            pvld       <= (state == IDLE) ? 1'b0 : track ? 1'b1 : pvld;
            cnt        <= (state == IDLE) ? '0 : deliver ? cnt_inc : cnt;
            smpl_valid <= deliver;
            smpl       <= deliver ? adc : smpl;
            busy       <= state_nx != IDLE;
            triggered  <= state_nx == STRM;
        end
    end

`ifdef SMPL_TRIG_AUTO_EN
    localparam int AW = $clog2(AUTO + 1);
    logic [AW-1:0] acnt;
    logic auto_q;

    assign auto_fire = tick && acnt == AW'(AUTO);
    assign trig_auto = auto_q;

    // Count Wait ticks toward the timeout and flag captures started by the timeout
    always_ff @(posedge clkSmpl or negedge n_reset) begin
        if (!n_reset) begin
            acnt   <= '0;
            auto_q <= 1'b0;
        end else begin
            acnt   <= (state != WAIT) ? '0 : (tick && acnt != AW'(AUTO)) ? acnt + 1'b1 : acnt;
            auto_q <= (state_nx == IDLE) ? 1'b0
                    : (fire && !hit && state_nx == STRM) ? 1'b1 : auto_q;
        end
    end
`else
    assign auto_fire = 1'b0;
    assign trig_auto = 1'b0;
`endif
endmodule

// File: tb/tb_smpl_trigger_ctrl.sv
// tb_smpl_trigger_ctrl: directed vector table plus multi-cycle sequences for smpl_trigger_ctrl
module tb_smpl_trigger_ctrl;
    logic clkSmpl = 1'b0;
    logic n_reset = 1'b0;
    logic adc_valid = 1'b0, arm = 1'b0, abort = 1'b0, cfg_edge = 1'b0, smpl_req = 1'b1;
    logic [7:0] adc = '0, cfg_level = 8'h80;
    logic [15:0] cfg_div = '0, cfg_holdoff = '0;
    logic smpl_valid, busy, triggered, trig_auto;
    logic [7:0] smpl;

    int vecs = 0;
    int errs = 0;
    logic [7:0] got[$];
    int fidx;
    logic tauto;

    smpl_trigger_ctrl #(.SN(8), .SIZE(4), .DW(16), .AUTO(8)) dut (
        .clkSmpl(clkSmpl), .n_reset(n_reset), .adc_valid(adc_valid), .adc(adc),
        .arm(arm), .abort(abort), .cfg_div(cfg_div), .cfg_holdoff(cfg_holdoff),
        .cfg_level(cfg_level), .cfg_edge(cfg_edge), .smpl_req(smpl_req),
        .smpl_valid(smpl_valid), .smpl(smpl), .busy(busy), .triggered(triggered),
        .trig_auto(trig_auto)
    );

    always #5 clkSmpl = ~clkSmpl;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic       arm, abort, vld;
        logic [7:0] adc;
        logic       req, ev;
        logic [7:0] es;
        logic       eb, et;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(posedge clkSmpl);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input logic [7:0] e0, e1, e2, e3);
        string s = "";
        logic ok;
        ok = got.size() == 4;
        if (ok) ok = got[0] === e0 && got[1] === e1 && got[2] === e2 && got[3] === e3;
        vecs++;
        if (!ok) begin
            errs++;
            foreach (got[i]) s = $sformatf("%s %h", s, got[i]);
            $display("FAIL %s: got [%s ] want [ %h %h %h %h ]", nm, s, e0, e1, e2, e3);
        end
    endtask

    // Arm, then feed n samples start+i*stp; smpl_req is low for indices dlo..dhi
    task automatic ramp(input int start, input int stp, input int n, input int dlo, input int dhi);
        got.delete();
        fidx = -1;
        tauto = 1'b0;
        arm = 1'b1;
        adc_valid = 1'b0;
        step();
        arm = 1'b0;
        for (int i = 0; i < n; i++) begin
            adc = 8'(start + i * stp);
            adc_valid = 1'b1;
            smpl_req = !(i >= dlo && i <= dhi);
            step();
            if (smpl_valid) begin
                if (fidx < 0) begin
                    fidx = i;
                    tauto = trig_auto;
                end
                got.push_back(smpl);
            end
        end
        adc_valid = 1'b0;
        smpl_req = 1'b1;
        step();
    endtask

    initial begin
        // basic rising trigger, then abort with simultaneous arm and re-arm
        tbl.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back({1'b1, 1'b0, 1'b1, 8'h7C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h7D, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h82, 1'b1, 1'b1, 8'h82, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h83, 1'b1, 1'b1, 8'h83, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h84, 1'b1, 1'b0, 8'h83, 1'b0, 1'b0});
        tbl.push_back({1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0});
        tbl.push_back({1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b0, 1'b0});
        tbl.push_back({1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 8'h83, 1'b1, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h90, 1'b1, 1'b1, 8'h90, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h91, 1'b1, 1'b1, 8'h91, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h92, 1'b1, 1'b1, 8'h92, 1'b1, 1'b1});
        tbl.push_back({1'b0, 1'b0, 1'b1, 8'h93, 1'b1, 1'b1, 8'h93, 1'b0, 1'b0});
        tbl.push_back({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h93, 1'b0, 1'b0});

        step();
        step();
        n_reset = 1'b1;
        foreach (tbl[i]) begin
            arm = tbl[i].arm;
            abort = tbl[i].abort;
            adc_valid = tbl[i].vld;
            adc = tbl[i].adc;
            smpl_req = tbl[i].req;
            step();
            check($sformatf("vec%0d {valid,smpl,busy,trig,auto}", i),
                  {19'd0, smpl_valid, smpl, busy, triggered, trig_auto},
                  {19'd0, tbl[i].ev, tbl[i].es, tbl[i].eb, tbl[i].et, 1'b0});
        end
        arm = 1'b0;
        abort = 1'b0;

        // decimation by 3 with holdoff of 3 ticks
        cfg_div = 16'd2;
        cfg_holdoff = 16'd3;
        cfg_level = 8'h10;
        ramp(0, 1, 40, 1000, 0);
        chk_q("decim_samples", 8'h12, 8'h15, 8'h18, 8'h1B);
        check("decim_first_idx", fidx, 18);
        check("decim_busy_end", {31'd0, busy}, 0);

        // falling edge with two dropped ticks mid-stream
        cfg_div = 16'd0;
        cfg_holdoff = 16'd0;
        cfg_level = 8'h80;
        cfg_edge = 1'b1;
        ramp(8'h84, -1, 14, 6, 7);
        chk_q("fall_backpressure", 8'h80, 8'h7F, 8'h7C, 8'h7B);
        check("fall_first_idx", fidx, 4);
        check("fall_busy_end", {31'd0, busy}, 0);
        cfg_edge = 1'b0;

        // async reset after two deliveries
        got.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adc = 8'(8'h7D + i);
            adc_valid = 1'b1;
            step();
            if (smpl_valid) got.push_back(smpl);
        end
        check("rst_pre_count", got.size(), 2);
        check("rst_pre_busy", {31'd0, busy}, 1);
        n_reset = 1'b0;
        #2;
        check("rst_outputs", {19'd0, smpl_valid, smpl, busy, triggered, trig_auto}, 0);
        adc_valid = 1'b0;
        step();
        n_reset = 1'b1;
        ramp(8'h7C, 1, 14, 1000, 0);
        chk_q("rst_rearm_frame", 8'h80, 8'h81, 8'h82, 8'h83);
        check("rst_rearm_tauto", {31'd0, tauto}, 0);

`ifdef SMPL_TRIG_AUTO_EN
        // no crossing: timeout forces the trigger on the 9th Wait tick
        ramp(8'h40, 0, 16, 1000, 0);
        chk_q("auto_samples", 8'h40, 8'h40, 8'h40, 8'h40);
        check("auto_first_idx", fidx, 9);
        check("auto_flag", {31'd0, tauto}, 1);
        check("auto_busy_end", {31'd0, busy}, 0);
`else
        // no crossing: Wait persists until abort
        ramp(8'h40, 0, 20, 1000, 0);
        check("wait_no_delivery", got.size(), 0);
        check("wait_busy", {30'd0, busy, trig_auto}, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("wait_abort_busy", {31'd0, busy}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
